// File: rtl/pipeline_control_pkg.sv
// pipeline_control_pkg
// Shared constants for the pipeline stall/flush controller.
// Contents: stage indices into the stall vector, the four RUN-state stall
// encodings, stall enable/disable levels, and the controller state encoding.
package pipeline_control_pkg;

    localparam int unsigned STAGE_PC  = 0;
    localparam int unsigned STAGE_IF  = 1;
    localparam int unsigned STAGE_ID  = 2;
    localparam int unsigned STAGE_EX  = 3;
    localparam int unsigned STAGE_MEM = 4;
    localparam int unsigned STAGE_WB  = 5;

    localparam int unsigned STALL_W = 6;

    // The oldest stalled stage is the first one that bubbles, so every younger
    // stage must hold with it.
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;

    localparam logic STALL_ENABLE  = 1'b1;
    localparam logic STALL_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_EXCEPT = 2'd1,
        ST_FLUSH  = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pipeline_control_stall_watchdog.sv
// pipeline_control_stall_watchdog
// Memory-stall watchdog: counts consecutive enabled cycles with the count
// condition true and emits a one-cycle pulse once STALL_TIMEOUT of them have
// been seen, then starts over.
// Ports:
//   i_clock      clock
//   i_reset      synchronous, active-high
//   i_enable     controller is in RUN
//   i_count_cond MEM stall request without an exception
//   o_timeout    registered one-cycle pulse
// Parameter STALL_TIMEOUT: 2..65535.
module pipeline_control_stall_watchdog #(
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_count_cond,
    output logic o_timeout
);

    localparam logic [15:0] TERMINAL = 16'(STALL_TIMEOUT - 1);

    logic [15:0] r_count;
    logic        r_timeout;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count   <= '0;
            r_timeout <= 1'b0;
        end else if (i_enable && i_count_cond) begin
            if (r_count == TERMINAL) begin
                r_count   <= '0;
                r_timeout <= 1'b1;
            end else begin
                r_count   <= r_count + 16'd1;
                r_timeout <= 1'b0;
            end
        end else begin
            r_count   <= '0;
            r_timeout <= 1'b0;
        end
    end

    assign o_timeout = r_timeout;

endmodule

// File: rtl/pipeline_control.sv
// pipeline_control
// Central stall/flush controller for the six-stage pipeline (PC IF ID EX MEM WB).
// Merges per-stage stall requests into the stall vector, sequences a two-cycle
// exception flush with PC redirect, counts stalled cycles (saturating) and
// optionally runs a memory-stall watchdog.
// Build option: define PIPELINE_CONTROL_STALL_TIMEOUT_EN to build the watchdog;
// otherwise stall_timeout is tied low and STALL_TIMEOUT is unused.
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   stall_request_id/ex/mem      per-stage hold requests
//   exception_valid/target       exception from MEM and its handler address
//   stall[5:0]                   combinational per-stage stall vector
//   flush                        clear all latches (registered state)
//   new_program_counter[31:0]    redirect address, valid while flush=1
//   stall_timeout                one-cycle watchdog pulse
//   stall_cycles[31:0]           saturating count of cycles with stall[0]=1
module pipeline_control
    import pipeline_control_pkg::*;
#(
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_request_id,
    input  logic        stall_request_ex,
    input  logic        stall_request_mem,
    input  logic        exception_valid,
    input  logic [31:0] exception_target,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_program_counter,
    output logic        stall_timeout,
    output logic [31:0] stall_cycles
);

    pc_state_t          r_state;
    pc_state_t          w_next_state;
    logic [STALL_W-1:0] w_stall;
    logic               w_capture;
    logic [31:0]        r_target;
    logic [31:0]        r_stall_cycles;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_stall      = STALL_NONE;
        w_capture    = 1'b0;
        case (r_state)
            ST_RUN: begin
                // An exception holds the front end and bubbles the excepting
                // instruction into WB so it never writes back.
                if (exception_valid) begin
                    w_stall      = STALL_MEM;
                    w_capture    = 1'b1;
                    w_next_state = ST_EXCEPT;
                end else if (stall_request_mem) begin
                    w_stall = STALL_MEM;
                end else if (stall_request_ex) begin
                    w_stall = STALL_EX;
                end else if (stall_request_id) begin
                    w_stall = STALL_ID;
                end
            end
            ST_EXCEPT: w_next_state = ST_FLUSH;
            ST_FLUSH:  w_next_state = ST_RUN;
            default:   w_next_state = ST_RUN;
        endcase
        if (reset) begin
            w_stall   = STALL_NONE;
            w_capture = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_target <= '0;
        end else if (w_capture) begin
            r_target <= exception_target;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if ((w_stall[STAGE_PC] == STALL_ENABLE) && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall               = w_stall;
    assign flush               = (r_state == ST_EXCEPT);
    assign new_program_counter = r_target;
    assign stall_cycles        = r_stall_cycles;

`ifdef PIPELINE_CONTROL_STALL_TIMEOUT_EN
    logic w_wd_enable;
    logic w_wd_count_cond;

    assign w_wd_enable     = (r_state == ST_RUN);
    assign w_wd_count_cond = stall_request_mem && !exception_valid;

    pipeline_control_stall_watchdog #(
        .STALL_TIMEOUT(STALL_TIMEOUT)
    ) u_stall_watchdog (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_enable    (w_wd_enable),
        .i_count_cond(w_wd_count_cond),
        .o_timeout   (stall_timeout)
    );
`else
    assign stall_timeout = STALL_DISABLE;
`endif

endmodule
